// File: rtl/au8_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : au8_sequencer
// Purpose  : Sequences an external 8-bit arithmetic unit through byte passes to
//            perform 16-bit ADD/SUB/INC/DEC and an 8x8 shift-add multiply.
// Revision : 1.0 - initial release
// ============================================================================
module au8_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] result,
    output logic        carry,
    output logic        au_sel1,
    output logic        au_sel0,
    output logic        au_cin,
    output logic [7:0]  au_x,
    output logic [7:0]  au_y,
    input  logic [7:0]  au_f,
    input  logic        au_cout
);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_LO   = 3'd1;
    localparam logic [2:0] c_ST_HI   = 3'd2;
    localparam logic [2:0] c_ST_MUL  = 3'd3;
    localparam logic [2:0] c_ST_DONE = 3'd4;

    localparam logic [2:0] c_OP_ADD = 3'd0;
    localparam logic [2:0] c_OP_SUB = 3'd1;
    localparam logic [2:0] c_OP_INC = 3'd2;
    localparam logic [2:0] c_OP_DEC = 3'd3;
    localparam logic [2:0] c_OP_MUL = 3'd4;

    logic [2:0]  r_state;
    logic [2:0]  r_op;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic        r_c_lo;
    logic [2:0]  r_cnt;
    logic [7:0]  r_acc_hi;
    logic [7:0]  r_acc_lo;
    logic [7:0]  r_mcand;
    logic        r_err;
    logic [15:0] r_result;
    logic        r_carry;

    logic [7:0]  w_mul_hi;
    logic [7:0]  w_mul_lo;

    assign busy   = (r_state != c_ST_IDLE);
    assign done   = (r_state == c_ST_DONE);
    assign err    = r_err;
    assign result = r_result;
    assign carry  = r_carry;

    // Shift the partial product right by one, unit carry-out becomes the new MSB.
    assign w_mul_hi = {au_cout, au_f[7:1]};
    assign w_mul_lo = {au_f[0], r_acc_lo[7:1]};

    always_comb begin
        au_sel1 = 1'b0;
        au_sel0 = 1'b0;
        au_cin  = 1'b0;
        au_x    = 8'h00;
        au_y    = 8'h00;
        case (r_state)
            c_ST_LO: begin
                au_x = r_a[7:0];
                au_y = r_b[7:0];
                case (r_op)
                    c_OP_ADD: au_sel0 = 1'b1;
                    c_OP_SUB: au_sel1 = 1'b1;
                    c_OP_INC: au_cin  = 1'b1;
                    c_OP_DEC: begin
                        au_sel1 = 1'b1;
                        au_sel0 = 1'b1;
                    end
                    default: ;
                endcase
            end
            c_ST_HI: begin
                au_x = r_a[15:8];
                au_y = r_b[15:8];
                case (r_op)
                    c_OP_ADD: begin
                        au_sel0 = 1'b1;
                        au_cin  = r_c_lo;
                    end
                    c_OP_SUB: begin
                        au_sel1 = 1'b1;
                        au_cin  = ~r_c_lo;
                    end
                    c_OP_INC: au_cin = r_c_lo;
                    // A low-byte carry means no borrow: pass the high byte through.
                    c_OP_DEC: begin
                        au_sel1 = ~r_c_lo;
                        au_sel0 = ~r_c_lo;
                    end
                    default: ;
                endcase
            end
            c_ST_MUL: begin
                au_x    = r_acc_hi;
                au_y    = r_mcand;
                au_sel0 = r_acc_lo[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_op     <= 3'd0;
            r_a      <= 16'h0000;
            r_b      <= 16'h0000;
            r_c_lo   <= 1'b0;
            r_cnt    <= 3'd0;
            r_acc_hi <= 8'h00;
            r_acc_lo <= 8'h00;
            r_mcand  <= 8'h00;
            r_err    <= 1'b0;
            r_result <= 16'h0000;
            r_carry  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_op  <= op;
                        r_a   <= a;
                        r_b   <= b;
                        r_err <= 1'b0;
                        if (op <= c_OP_DEC) begin
                            r_state <= c_ST_LO;
                        end else if (op == c_OP_MUL) begin
                            r_cnt    <= 3'd0;
                            r_acc_hi <= 8'h00;
                            r_acc_lo <= a[7:0];
                            r_mcand  <= b[7:0];
                            r_state  <= c_ST_MUL;
                        end else begin
                            r_err    <= 1'b1;
                            r_result <= 16'h0000;
                            r_carry  <= 1'b0;
                            r_state  <= c_ST_DONE;
                        end
                    end
                end
                c_ST_LO: begin
                    r_result[7:0] <= au_f;
                    r_c_lo        <= au_cout;
                    r_state       <= c_ST_HI;
                end
                c_ST_HI: begin
                    r_result[15:8] <= au_f;
                    r_carry        <= ((r_op == c_OP_DEC) && r_c_lo) ? 1'b1 : au_cout;
                    r_state        <= c_ST_DONE;
                end
                c_ST_MUL: begin
                    r_acc_hi <= w_mul_hi;
                    r_acc_lo <= w_mul_lo;
                    r_cnt    <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_result <= {w_mul_hi, w_mul_lo};
                        r_carry  <= 1'b0;
                        r_state  <= c_ST_DONE;
                    end
                end
                c_ST_DONE: r_state <= c_ST_IDLE;
                default:   r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_au8_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_au8_sequencer
// Purpose  : Scoreboard bench for au8_sequencer with a behavioural arithmetic
//            unit and an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_au8_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [15:0] a = 16'h0;
    logic [15:0] b = 16'h0;
    logic        busy, done, err, carry;
    logic [15:0] result;
    logic        au_sel1, au_sel0, au_cin;
    logic [7:0]  au_x, au_y, au_f;
    logic        au_cout;

    au8_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .err(err), .result(result), .carry(carry),
        .au_sel1(au_sel1), .au_sel0(au_sel0), .au_cin(au_cin),
        .au_x(au_x), .au_y(au_y), .au_f(au_f), .au_cout(au_cout)
    );

    always #5 clk = ~clk;

    // Behavioural external arithmetic unit
    logic [8:0] au_sum;
    always_comb begin
        case ({au_sel1, au_sel0})
            2'b00:   au_sum = {1'b0, au_x} + {8'b0, au_cin};
            2'b01:   au_sum = {1'b0, au_x} + {1'b0, au_y} + {8'b0, au_cin};
            2'b10:   au_sum = {1'b0, au_x} + {1'b0, ~au_y} + {8'b0, ~au_cin};
            default: au_sum = {1'b0, au_x} + 9'h0FF;
        endcase
    end
    assign au_f    = au_sum[7:0];
    assign au_cout = au_sum[8];

    typedef struct {
        logic [15:0] res;
        logic        c;
        logic        e;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   n_acc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
        exp_t r;
        logic [16:0] s;
        r.e = 1'b0; r.c = 1'b0; r.res = 16'h0; r.acc = 0; r.lat = 3;
        case (o)
            3'd0: begin s = {1'b0, x} + {1'b0, y}; r.res = s[15:0]; r.c = s[16]; end
            3'd1: begin r.res = x - y; r.c = (x >= y); end
            3'd2: begin r.res = x + 16'd1; r.c = (x == 16'hFFFF); end
            3'd3: begin r.res = x - 16'd1; r.c = (x != 16'h0000); end
            3'd4: begin r.res = 16'(x[7:0] * y[7:0]); r.lat = 9; end
            default: begin r.e = 1'b1; r.lat = 1; end
        endcase
        return r;
    endfunction

    // Accept monitor: predicts the response for every accepted request
    always begin
        logic        p;
        logic [2:0]  po;
        logic [15:0] pa, pb;
        exp_t        e;
        @(negedge clk);
        #2;
        p = start && !busy && !rst;
        po = op; pa = a; pb = b;
        @(posedge clk);
        #1;
        if (p) begin
            e = model(po, pa, pb);
            e.acc = cyc;
            sb.push_back(e);
            n_acc++;
        end
    end

    // Completion monitor
    always begin
        exp_t e;
        @(posedge clk);
        #3;
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done_queue", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                chk("result",  result, e.res);
                chk("carry",   carry, e.c);
                chk("err",     err, e.e);
                chk("busy_at_done", busy, 1);
                chk("latency", cyc - e.acc + 1, e.lat);
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
        int guard = 0;
        @(negedge clk);
        while (busy && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        if (busy) chk("issue_wait_busy", busy, 0);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = 3'($urandom); a = 16'($urandom); b = 16'($urandom);
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_queue", sb.size(), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"},   busy, 0);
        chk({tag, "_done"},   done, 0);
        chk({tag, "_err"},    err, 0);
        chk({tag, "_carry"},  carry, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_au"}, {au_sel1, au_sel0, au_cin, au_x, au_y}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (errors so far %0d)", n_err);
        $fatal(1);
    end

    initial begin
        logic [7:0] mx;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // Directed vectors
        issue(3'd0, 16'h12F0, 16'h0110);
        issue(3'd0, 16'hFFFF, 16'h0001);
        issue(3'd1, 16'h1000, 16'h0001);
        issue(3'd1, 16'h0001, 16'h0002);
        issue(3'd2, 16'h00FF, 16'h0000);
        issue(3'd2, 16'hFFFF, 16'h0000);
        issue(3'd3, 16'h0100, 16'h0000);
        issue(3'd3, 16'h0000, 16'h0000);
        issue(3'd6, 16'h1234, 16'h5678);

        // Multiply: unit add-select follows multiplier bits LSB-first
        mx = 8'hFF;
        issue(3'd4, {8'hAA, mx}, 16'h00FF);
        for (int i = 0; i < 8; i++) begin
            chk("mul_sel0_ff", au_sel0, mx[i]);
            @(negedge clk);
        end
        mx = 8'h20;
        issue(3'd4, {8'h00, mx}, 16'h5510);
        for (int i = 0; i < 8; i++) begin
            chk("mul_sel0_20", au_sel0, mx[i]);
            chk("mul_sel1", au_sel1, 0);
            @(negedge clk);
        end
        drain();

        // Start held high: one accept every four cycles
        @(negedge clk);
        n_acc = 0;
        start = 1'b1; op = 3'd0; a = 16'h0102; b = 16'h0304;
        repeat (12) @(negedge clk);
        start = 1'b0;
        chk("held_start_accepts", n_acc, 3);
        drain();

        // Start pulsed while busy is dropped
        issue(3'd0, 16'h1111, 16'h2222);
        start = 1'b1; op = 3'd1; a = 16'hFFFF; b = 16'h0001;
        @(negedge clk);
        start = 1'b0;
        drain();

        // Reset in the middle of a multiply
        issue(3'd4, 16'h00B7, 16'h0059);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check_idle_outputs("midrst");
        rst = 1'b0;
        issue(3'd0, 16'h7FFF, 16'h8001);
        drain();

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
